// File: rtl/spi_byte_control_pkg.sv
// ============================================================================
// Module : spi_byte_control_pkg
// Brief  : Register map, status bits and FSM state encoding for spi_byte_control
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_byte_control_pkg;

    localparam int         SPI_DATA_WIDTH  = 8;
    localparam logic [2:0] SPI_ADDR_RXDATA = 3'd0;
    localparam logic [2:0] SPI_ADDR_TXDATA = 3'd1;
    localparam logic [2:0] SPI_ADDR_STATUS = 3'd2;
    localparam logic [2:0] SPI_ADDR_SSMASK = 3'd4;
    localparam logic [7:0] SPI_SSMASK_VAL  = 8'h01;
    localparam int         SPI_TRDY_BIT    = 6;
    localparam int         SPI_RRDY_BIT    = 7;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SEL     = 4'd1,
        ST_TXP_REQ = 4'd2,
        ST_TXP_CHK = 4'd3,
        ST_TX_WR   = 4'd4,
        ST_RXP_REQ = 4'd5,
        ST_RXP_CHK = 4'd6,
        ST_RD_REQ  = 4'd7,
        ST_RD_CAP  = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_byte_control.sv
// ============================================================================
// Module : spi_byte_control
// Brief  : Sequences one full-duplex SPI byte through the master's registers
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_byte_control
    import spi_byte_control_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter logic [2:0]            ADDR_RXDATA = SPI_ADDR_RXDATA,
    parameter logic [2:0]            ADDR_TXDATA = SPI_ADDR_TXDATA,
    parameter logic [2:0]            ADDR_STATUS = SPI_ADDR_STATUS,
    parameter logic [2:0]            ADDR_SSMASK = SPI_ADDR_SSMASK,
    parameter logic [DATA_WIDTH-1:0] SSMASK_VAL  = DATA_WIDTH'(SPI_SSMASK_VAL),
    parameter int                    TRDY_BIT    = SPI_TRDY_BIT,
    parameter int                    RRDY_BIT    = SPI_RRDY_BIT
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] o_data,
    output logic                  I_TX_EN,
    output logic [2:0]            I_WADDR,
    output logic [DATA_WIDTH-1:0] I_WDATA,
    output logic                  I_RX_EN,
    output logic [2:0]            I_RADDR,
    input  logic [DATA_WIDTH-1:0] O_RDATA,
    output logic [5:0]            wr_index,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  is_sending
);

    state_t                state;
    state_t                state_next;
    logic                  tx_en_next;
    logic [2:0]            waddr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic                  rx_en_next;
    logic [2:0]            raddr_next;
    logic [5:0]            index_next;
    logic [DATA_WIDTH-1:0] rbyte_next;
    logic                  busy_next;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state      <= ST_IDLE;
            I_TX_EN    <= 1'b0;
            I_WADDR    <= 3'd0;
            I_WDATA    <= '0;
            I_RX_EN    <= 1'b0;
            I_RADDR    <= 3'd0;
            wr_index   <= 6'd0;
            i_data     <= '0;
            is_sending <= 1'b0;
        end else begin
            state      <= state_next;
            I_TX_EN    <= tx_en_next;
            I_WADDR    <= waddr_next;
            I_WDATA    <= wdata_next;
            I_RX_EN    <= rx_en_next;
            I_RADDR    <= raddr_next;
            wr_index   <= index_next;
            i_data     <= rbyte_next;
            is_sending <= busy_next;
        end
    end

    // Master read data is sampled in the *_CHK / RD_CAP states, i.e. the cycle
    // in which the registered read strobe is presented to the master.
    always_comb begin
        state_next = state;
        tx_en_next = 1'b0;
        waddr_next = I_WADDR;
        wdata_next = I_WDATA;
        rx_en_next = 1'b0;
        raddr_next = I_RADDR;
        index_next = wr_index;
        rbyte_next = i_data;
        busy_next  = is_sending;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SEL;
                    busy_next  = 1'b1;
                end
            end
            ST_SEL: begin
                tx_en_next = 1'b1;
                waddr_next = ADDR_SSMASK;
                wdata_next = SSMASK_VAL;
                state_next = ST_TXP_REQ;
            end
            ST_TXP_REQ: begin
                rx_en_next = 1'b1;
                raddr_next = ADDR_STATUS;
                state_next = ST_TXP_CHK;
            end
            ST_TXP_CHK: begin
                state_next = O_RDATA[TRDY_BIT] ? ST_TX_WR : ST_TXP_REQ;
            end
            ST_TX_WR: begin
                tx_en_next = 1'b1;
                waddr_next = ADDR_TXDATA;
                wdata_next = o_data;
                state_next = ST_RXP_REQ;
            end
            ST_RXP_REQ: begin
                rx_en_next = 1'b1;
                raddr_next = ADDR_STATUS;
                state_next = ST_RXP_CHK;
            end
            ST_RXP_CHK: begin
                state_next = O_RDATA[RRDY_BIT] ? ST_RD_REQ : ST_RXP_REQ;
            end
            ST_RD_REQ: begin
                rx_en_next = 1'b1;
                raddr_next = ADDR_RXDATA;
                state_next = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rbyte_next = O_RDATA;
                busy_next  = 1'b0;
                index_next = wr_index + 6'd1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_control.sv
// ============================================================================
// Module : tb_spi_byte_control
// Brief  : Directed bench for spi_byte_control with a register-level slave model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_byte_control;

    logic       I_CLK   = 1'b0;
    logic       I_RESET = 1'b1;
    logic       start   = 1'b0;
    logic [7:0] o_data  = 8'h00;
    logic       I_TX_EN;
    logic [2:0] I_WADDR;
    logic [7:0] I_WDATA;
    logic       I_RX_EN;
    logic [2:0] I_RADDR;
    logic [7:0] O_RDATA;
    logic [5:0] wr_index;
    logic [7:0] i_data;
    logic       is_sending;

    spi_byte_control dut (
        .I_CLK      (I_CLK),
        .I_RESET    (I_RESET),
        .start      (start),
        .o_data     (o_data),
        .I_TX_EN    (I_TX_EN),
        .I_WADDR    (I_WADDR),
        .I_WDATA    (I_WDATA),
        .I_RX_EN    (I_RX_EN),
        .I_RADDR    (I_RADDR),
        .O_RDATA    (O_RDATA),
        .wr_index   (wr_index),
        .i_data     (i_data),
        .is_sending (is_sending)
    );

    always #5 I_CLK = ~I_CLK;

    // Slave model: status poll k (counted from poll_base) reports TRDY once
    // k >= trdy_low, and RRDY once the TX polls plus rrdy_low polls are done.
    logic [7:0] rx_byte       = 8'hA5;
    int         status_reads  = 0;
    int         rxdata_reads  = 0;
    int         ssmask_writes = 0;
    int         txdata_writes = 0;
    int         tx_viol       = 0;
    int         rx_viol       = 0;
    logic [7:0] last_txdata   = 8'h00;
    int         poll_base     = 0;
    int         trdy_low      = 0;
    int         rrdy_low      = 0;
    int         polls;

    assign polls = status_reads - poll_base;

    always_comb begin
        O_RDATA = 8'h00;
        if (I_RADDR == 3'd0) begin
            O_RDATA = rx_byte;
        end else if (I_RADDR == 3'd2) begin
            O_RDATA[6] = (polls >= trdy_low);
            O_RDATA[7] = (polls >= trdy_low + 1 + rrdy_low);
        end
    end

    always @(posedge I_CLK) begin
        if (I_RX_EN && I_RADDR == 3'd2) status_reads <= status_reads + 1;
        if (I_RX_EN && I_RADDR == 3'd0) begin
            rxdata_reads <= rxdata_reads + 1;
            if (polls < trdy_low + rrdy_low + 2) rx_viol <= rx_viol + 1;
        end
        if (I_TX_EN && I_WADDR == 3'd4) ssmask_writes <= ssmask_writes + 1;
        if (I_TX_EN && I_WADDR == 3'd1) begin
            txdata_writes <= txdata_writes + 1;
            last_txdata   <= I_WDATA;
            if (polls < trdy_low + 1) tx_viol <= tx_viol + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".tx_en"},   32'(I_TX_EN),    32'h0);
        check({tag, ".rx_en"},   32'(I_RX_EN),    32'h0);
        check({tag, ".waddr"},   32'(I_WADDR),    32'h0);
        check({tag, ".raddr"},   32'(I_RADDR),    32'h0);
        check({tag, ".wdata"},   32'(I_WDATA),    32'h0);
        check({tag, ".i_data"},  32'(i_data),     32'h0);
        check({tag, ".index"},   32'(wr_index),   32'h0);
        check({tag, ".sending"}, 32'(is_sending), 32'h0);
    endtask

    // Called with is_sending already observed high for len_in cycles.
    task automatic run_out(input int len_in, output int len);
        len = len_in;
        while (is_sending === 1'b1 && len < 500) begin
            tick();
            if (is_sending === 1'b1) len++;
        end
    endtask

    initial begin
        int len;
        int s_tx;
        int s_st;
        int s_rx;
        int s_ss;
        int cnt;
        int gap_bad;
        int len_bad;
        logic [5:0] w62;
        logic [5:0] w63;
        logic found;

        // Reset and idle
        repeat (3) tick();
        check_zero("reset");
        I_RESET = 1'b0;
        repeat (3) tick();
        check_zero("idle");

        // Minimum-length transfer, ready bits on first poll
        poll_base = status_reads; trdy_low = 0; rrdy_low = 0;
        rx_byte = 8'hA5; o_data = 8'h46;
        s_ss = ssmask_writes; s_tx = txdata_writes;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sel.sending", 32'(is_sending), 32'h1);
        check("sel.tx_en",   32'(I_TX_EN),    32'h0);
        tick();
        check("ssmask.tx_en", 32'(I_TX_EN), 32'h1);
        check("ssmask.waddr", 32'(I_WADDR), 32'h4);
        check("ssmask.wdata", 32'(I_WDATA), 32'h01);
        run_out(2, len);
        check("min.len",      32'(len),                   32'd8);
        check("min.i_data",   32'(i_data),                32'hA5);
        check("min.index",    32'(wr_index),              32'd1);
        check("min.txdata",   32'(last_txdata),           32'h46);
        check("min.txwrites", 32'(txdata_writes - s_tx),  32'd1);
        check("min.sswrites", 32'(ssmask_writes - s_ss),  32'd1);

        // TRDY low for 5 polls, RRDY low for 3 polls
        tick();
        poll_base = status_reads; trdy_low = 5; rrdy_low = 3;
        rx_byte = 8'h3C; o_data = 8'h41;
        s_st = status_reads; s_rx = rxdata_reads;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_out(1, len);
        check("poll.len",     32'(len),                  32'd24);
        check("poll.status",  32'(status_reads - s_st),  32'd10);
        check("poll.rxreads", 32'(rxdata_reads - s_rx),  32'd1);
        check("poll.txdata",  32'(last_txdata),          32'h41);
        check("poll.tx_viol", 32'(tx_viol),              32'd0);
        check("poll.rx_viol", 32'(rx_viol),              32'd0);
        check("poll.i_data",  32'(i_data),               32'h3C);
        check("poll.index",   32'(wr_index),             32'd2);

        // o_data updated one cycle after is_sending rises
        tick();
        poll_base = status_reads; trdy_low = 0; rrdy_low = 0;
        o_data = 8'h46;
        start = 1'b1;
        tick();
        start = 1'b0;
        o_data = 8'h52;
        run_out(1, len);
        check("late.txdata", 32'(last_txdata), 32'h52);
        check("late.index",  32'(wr_index),    32'd3);

        // 70 back-to-back transfers from a fresh reset
        I_RESET = 1'b1;
        tick();
        I_RESET = 1'b0;
        check("b2b.index0", 32'(wr_index), 32'd0);
        poll_base = status_reads; rx_byte = 8'h5A;
        gap_bad = 0; len_bad = 0; w62 = '0; w63 = '1;
        start = 1'b1;
        for (int t = 0; t < 70; t++) begin
            cnt = 0;
            while (is_sending !== 1'b1 && cnt < 20) begin
                tick();
                cnt++;
            end
            if (t > 0 && cnt != 1) gap_bad++;
            len = 0;
            while (is_sending === 1'b1 && len < 50) begin
                tick();
                len++;
            end
            if (len != 8) len_bad++;
            if (t == 62) w62 = wr_index;
            if (t == 63) w63 = wr_index;
            if (t == 69) start = 1'b0;
        end
        check("b2b.gaps",   32'(gap_bad),  32'd0);
        check("b2b.lens",   32'(len_bad),  32'd0);
        check("b2b.idx63",  32'(w62),      32'd63);
        check("b2b.wrap",   32'(w63),      32'd0);
        check("b2b.final",  32'(wr_index), 32'd6);
        check("b2b.i_data", 32'(i_data),   32'h5A);

        // Reset while polling RRDY
        I_RESET = 1'b1;
        tick();
        I_RESET = 1'b0;
        tick();
        poll_base = status_reads; trdy_low = 0; rrdy_low = 1000;
        rx_byte = 8'hC3;
        s_tx = txdata_writes; s_rx = rxdata_reads;
        found = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (I_RX_EN === 1'b1 && I_RADDR == 3'd2 && txdata_writes > s_tx) begin
                found = 1'b1;
                break;
            end
        end
        check("abort.reached", 32'(found), 32'h1);
        I_RESET = 1'b1;
        tick();
        check_zero("abort");
        I_RESET = 1'b0;
        s_st = status_reads;
        repeat (10) tick();
        check("abort.sending", 32'(is_sending),            32'h0);
        check("abort.status",  32'(status_reads - s_st),   32'd0);
        check("abort.rxreads", 32'(rxdata_reads - s_rx),   32'd0);
        check("abort.i_data",  32'(i_data),                32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
